// File: rtl/key_event_fifo.sv
// Purpose : turns keyboard scan-code changes into {press,code} events queued in a FWFT FIFO, and tracks WASD held state.
// Latency : input change sampled at edge N is written at edge N+1; with an empty FIFO ev_valid rises after edge N+1.
// Backpr. : consumer pops with ev_ready while ev_valid; a push that finds the FIFO full without a same-cycle pop is dropped and sets sticky overflow.
//
// Ports:
//   Clk        system clock, all state changes on its rising edge
//   reset_n    asynchronous active-low reset of all control state
//   keyCode    current scan code from the keyboard stage
//   press      1 = keyCode held, 0 = keyCode released
//   ev_ready   consumer pop request (ignored while the FIFO is empty)
//   clear_ovf  clears the overflow flag (a drop in the same cycle wins)
//   ev_valid   FIFO head is valid (count != 0)
//   ev_code    scan code at the FIFO head (8'h00 when empty)
//   ev_press   press/release bit at the FIFO head (0 when empty)
//   count      number of occupied entries, 0..DEPTH
//   overflow   sticky flag: at least one event was dropped
//   key_held   held state of {W,A,S,D} = {8'h1D,8'h1C,8'h1B,8'h23}
module key_event_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     Clk,
    input  logic                     reset_n,
    input  logic [7:0]               keyCode,
    input  logic                     press,
    input  logic                     ev_ready,
    input  logic                     clear_ovf,
    output logic                     ev_valid,
    output logic [7:0]               ev_code,
    output logic                     ev_press,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [3:0]               key_held
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    localparam logic [7:0] CODE_W = 8'h1D;
    localparam logic [7:0] CODE_A = 8'h1C;
    localparam logic [7:0] CODE_S = 8'h1B;
    localparam logic [7:0] CODE_D = 8'h23;

    // ------------------------------------------------------------------
    // Input sampling and change detection
    // ------------------------------------------------------------------
    logic [8:0] in_q;
    logic [8:0] prev_q;
    logic       evt;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q   <= 9'h000;
            prev_q <= 9'h000;
        end else begin
            in_q   <= {press, keyCode};
            prev_q <= in_q;
        end
    end

    // Any change of {press,code} is an event, except that code 8'h00 means
    // "no key" and never produces one.
    assign evt = (in_q != prev_q) && (in_q[7:0] != 8'h00);

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign ev_valid = (count != '0);
    assign full     = (count == CNT_FULL);

    // A pop needs a valid head, so ev_ready on an empty FIFO does nothing.
    assign do_pop  = ev_valid && ev_ready;
    // When full, a same-cycle pop frees the slot the push needs.
    assign do_push = evt && (!full || do_pop);
    assign drop    = evt && full && !do_pop;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage holds data only; validity is tracked by count, so it needs no reset.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= in_q;
        end
    end

    // Head is masked to zero when empty so the outputs are defined during reset.
    logic [8:0] head;
    assign head     = mem[rd_ptr];
    assign ev_code  = ev_valid ? head[7:0] : 8'h00;
    assign ev_press = ev_valid ? head[8]   : 1'b0;

    // ------------------------------------------------------------------
    // Sticky overflow: a drop in the same cycle beats clear_ovf
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // WASD held state follows every detected event, even dropped ones
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            key_held <= 4'h0;
        end else if (evt) begin
            case (in_q[7:0])
                CODE_W:  key_held[3] <= in_q[8];
                CODE_A:  key_held[2] <= in_q[8];
                CODE_S:  key_held[1] <= in_q[8];
                CODE_D:  key_held[0] <= in_q[8];
                default: key_held    <= key_held;
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_fifo.sv
// Purpose : self-checking bench for key_event_fifo using a queue-based event model plus directed literal checks.
// Latency : model mirrors the two-stage sample/push timing at the behavioural level.
// Backpr. : exercises pop on empty, overflow drop, full push+pop, clear_ovf vs drop.
module tb_key_event_fifo;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          Clk;
    logic          reset_n;
    logic [7:0]    keyCode;
    logic          press;
    logic          ev_ready;
    logic          clear_ovf;
    logic          ev_valid;
    logic [7:0]    ev_code;
    logic          ev_press;
    logic [CW-1:0] count;
    logic          overflow;
    logic [3:0]    key_held;

    key_event_fifo #(.DEPTH(DEPTH)) dut (
        .Clk       (Clk),
        .reset_n   (reset_n),
        .keyCode   (keyCode),
        .press     (press),
        .ev_ready  (ev_ready),
        .clear_ovf (clear_ovf),
        .ev_valid  (ev_valid),
        .ev_code   (ev_code),
        .ev_press  (ev_press),
        .count     (count),
        .overflow  (overflow),
        .key_held  (key_held)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: last two sampled inputs, a queue of events,
    // a sticky flag and a held-key vector.
    // ------------------------------------------------------------------
    logic [8:0] m_cur;
    logic [8:0] m_last;
    logic [8:0] mq[$];
    logic       m_ovf;
    logic [3:0] m_held;

    always @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cur  = 9'h000;
            m_last = 9'h000;
            mq.delete();
            m_ovf  = 1'b0;
            m_held = 4'h0;
        end else begin
            logic have_ev;
            logic want_pop;
            logic dropped;
            have_ev  = (m_cur != m_last) && (m_cur[7:0] != 8'h00);
            want_pop = (mq.size() != 0) && ev_ready;
            dropped  = 1'b0;
            if (want_pop) void'(mq.pop_front());
            if (have_ev) begin
                if (mq.size() < DEPTH) mq.push_back(m_cur);
                else dropped = 1'b1;
            end
            if (dropped) m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            if (have_ev) begin
                if (m_cur[7:0] == 8'h1D) m_held[3] = m_cur[8];
                if (m_cur[7:0] == 8'h1C) m_held[2] = m_cur[8];
                if (m_cur[7:0] == 8'h1B) m_held[1] = m_cur[8];
                if (m_cur[7:0] == 8'h23) m_held[0] = m_cur[8];
            end
            m_last = m_cur;
            m_cur  = {press, keyCode};
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge Clk) begin
        if (reset_n) begin
            chk("m_valid", ev_valid, (mq.size() != 0));
            chk("m_count", count, mq.size());
            chk("m_overflow", overflow, m_ovf);
            chk("m_key_held", key_held, m_held);
            if (mq.size() != 0) begin
                chk("m_code", ev_code, mq[0][7:0]);
                chk("m_press", ev_press, mq[0][8]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic drive(input logic p, input logic [7:0] c);
        press   = p;
        keyCode = c;
    endtask

    task automatic pop1;
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b0;
        keyCode   = 8'h00;
        press     = 1'b0;
        ev_ready  = 1'b0;
        clear_ovf = 1'b0;

        // Reset values, before any clock edge
        #3;
        chk("rst_valid", ev_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_code", ev_code, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_held", key_held, 4'h0);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        chk("idle_count", count, 0);

        // Single event: W press, visible after the second edge
        drive(1'b1, 8'h1D);
        tick(1);
        chk("lat_not_yet", ev_valid, 0);
        tick(1);
        chk("single_valid", ev_valid, 1);
        chk("single_code", ev_code, 8'h1D);
        chk("single_press", ev_press, 1);
        chk("single_count", count, 1);
        chk("single_held", key_held, 4'b1000);

        // Release and pop in order
        drive(1'b0, 8'h1D);
        tick(2);
        chk("rel_count", count, 2);
        chk("rel_head_press", ev_press, 1);
        pop1();
        chk("pop1_code", ev_code, 8'h1D);
        chk("pop1_press", ev_press, 0);
        chk("pop1_count", count, 1);
        chk("rel_held", key_held, 4'b0000);
        pop1();
        chk("pop2_count", count, 0);
        pop1();  // ev_ready on empty is ignored
        chk("pop_empty_count", count, 0);

        // Overflow: nine events into eight slots
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 8'h10 + 8'(i));
            tick(1);
        end
        tick(2);
        chk("ovf_count", count, 8);
        chk("ovf_flag", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_pop_code", ev_code, 8'h10 + 8'(i));
            pop1();
        end
        chk("ovf_drained", count, 0);
        chk("ovf_sticky", overflow, 1);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'h20 + 8'(i));
            tick(1);
        end
        tick(2);
        chk("full_count", count, 8);
        drive(1'b1, 8'h30);
        tick(1);
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
        chk("pp_count", count, 8);
        chk("pp_ovf", overflow, 0);
        chk("pp_head", ev_code, 8'h21);

        // Drop coincident with clear_ovf: set wins; D held even though dropped
        drive(1'b1, 8'h23);
        tick(1);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;
        chk("setwins_ovf", overflow, 1);
        chk("setwins_count", count, 8);
        chk("drop_held", key_held, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            chk("pp_pop_code", ev_code, (i < 7) ? 8'h21 + 8'(i) : 8'h30);
            pop1();
        end
        chk("pp_drained", count, 0);
        clear_ovf = 1'b1;
        tick(1);
        clear_ovf = 1'b0;

        // Filtering: unchanged input, and code 8'h00
        tick(20);
        chk("hold_count", count, 0);
        drive(1'b1, 8'h00);
        tick(3);
        chk("zero_press_count", count, 0);
        drive(1'b0, 8'h00);
        tick(3);
        chk("zero_rel_count", count, 0);

        // Queue a few events, then reset mid-queue
        drive(1'b1, 8'h1C);
        tick(1);
        drive(1'b1, 8'h1B);
        tick(1);
        drive(1'b1, 8'h1D);
        tick(2);
        chk("mq_count", count, 3);
        chk("mq_held", key_held, 4'b1111);
        @(posedge Clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", ev_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_code", ev_code, 8'h00);
        chk("arst_press", ev_press, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_held", key_held, 4'h0);
        drive(1'b0, 8'h00);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("post_rst_count", count, 0);
        drive(1'b1, 8'h1C);
        tick(2);
        chk("post_rst_code", ev_code, 8'h1C);
        chk("post_rst_held", key_held, 4'b0100);
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/key_event_fifo.md
KEY_EVENT_FIFO -- requirements
Module: key_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries (power of two, 2..16).
REQ-002 SHALL have port Clk, input, 1, the system clock; every register changes only on its rising edge except at reset.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port keyCode, input, 8, the current scan code from the keyboard stage, synchronous to Clk.
REQ-005 SHALL have port press, input, 1; 1 means keyCode is held, 0 means keyCode was released.
REQ-006 SHALL have port ev_ready, input, 1, the consumer pop request.
REQ-007 SHALL have port clear_ovf, input, 1, which clears the overflow flag.
REQ-008 SHALL have port ev_valid, output, 1; 1 means the FIFO head is valid.
REQ-009 SHALL have port ev_code, output, 8, the scan code at the FIFO head.
REQ-010 SHALL have port ev_press, output, 1, the press/release bit at the FIFO head.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, the number of occupied entries.
REQ-012 SHALL have port overflow, output, 1, a sticky flag meaning an event was dropped.
REQ-013 SHALL have port key_held, output, 4, with bits [3:0] holding the held state of W(8'h1D), A(8'h1C), S(8'h1B), D(8'h23).

Function
REQ-014 SHALL register {press,keyCode} into in_q every Clk and keep prev_q, the previous in_q value.
REQ-015 SHALL detect an event when in_q != prev_q and in_q[7:0] != 8'h00.
REQ-016 SHALL write a detected event as {press,code} into the FIFO on the next Clk edge.
- Latency: input change before edge N -> ev_valid=1 after edge N+1 if the FIFO was empty.
REQ-017 SHALL operate the FIFO first-word-fall-through: ev_code/ev_press show the head whenever ev_valid=1.
REQ-018 SHALL pop on a Clk edge only when ev_valid=1 and ev_ready=1.
- ev_ready with the FIFO empty SHALL be ignored.
REQ-019 SHALL set ev_valid = (count != 0).
REQ-020 SHALL drop a push that finds the FIFO full with no pop in the same cycle, and SHALL set overflow.
- count, pointers and stored data SHALL be unchanged in that case.
REQ-021 SHALL perform both operations when a push and a pop occur in the same cycle.
- When full: the head is popped, the new event is written, count is unchanged, overflow is not set.
- When empty: the push proceeds and the pop is ignored.
REQ-022 SHALL use read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- count SHALL equal the number of pushes minus pops, saturating at 0..DEPTH.
REQ-023 SHALL clear overflow when clear_ovf=1, except that a drop in the same cycle SHALL set it (set wins).
REQ-024 SHALL update key_held on every detected event, regardless of FIFO fullness.
- The matching bit is set to press; events for non-WASD codes leave key_held unchanged.
REQ-025 SHALL leave ev_code/ev_press contents don't-care when ev_valid=0, with ev_valid as the only qualifier.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force:
- in_q, prev_q = 9'h000
- pointers = 0, count = 0, ev_valid = 0, overflow = 0, key_held = 4'h0
- ev_code = 8'h00, ev_press = 0
REQ-027 SHALL discard all queued events when reset asserts mid-operation, and SHALL detect no event on the first edge after release unless the inputs differ from 0/8'h00.
REQ-028 SHALL not need FIFO data storage to be reset; only the control state is reset.

Verification
REQ-029 Single event: reset, hold ev_ready=0, then drive press=1, keyCode=8'h1D at edge N.
- Required: ev_valid=1 after edge N+1, ev_code=8'h1D, ev_press=1, count=1, key_held=4'b1000.
REQ-030 Release and pop: continuing from REQ-029, drive press=0 with keyCode=8'h1D, then pulse ev_ready.
- Required: events (1D,1) then (1D,0) in that order, count returning to 0, key_held=4'b0000.
REQ-031 Overflow: DEPTH=8 with ev_ready=0, generate 9 distinct events (codes 8'h10..8'h18, press=1).
- Required: count=8, overflow=1, and popping yields 8'h10..8'h17 with 8'h18 lost.
REQ-032 Full with simultaneous push/pop: with the FIFO full, hold ev_ready=1 during a new event.
- Required: count stays 8, overflow stays 0, and the new code appears last.
- Also: clear_ovf coincident with a drop leaves overflow=1.
REQ-033 Filtering and mid-operation reset: hold an unchanged input for 20 cycles, and drive keyCode=8'h00 with press=1.
- Required: no events for either.
- Then: pulse reset_n low mid-queue -> all outputs at their REQ-026 values immediately, before any Clk edge.
